mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between fetch and load/store with fixed data-over-inst priority.
// Keeps an in-order id FIFO so that each response returns to the side that issued the request.
module mem_port_arbiter #(
  parameter int OT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [2:0]  ot_count
);

  localparam int              PTR_W     = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OT_DEPTH - 1);
  localparam logic [2:0]      DEPTH_CNT = 3'(OT_DEPTH);

  logic [OT_DEPTH-1:0] id_q, id_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [2:0]          count_q, count_d;

  logic full;
  logic grant_data;
  logic grant_inst;
  logic push;
  logic pop;
  logic head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full       = (count_q == DEPTH_CNT);
    grant_data = data_req & ~full;
    grant_inst = inst_req & ~data_req & ~full;
    mem_req    = (inst_req | data_req) & ~full;
    push       = mem_req & mem_addr_ok;
    pop        = mem_data_ok & (count_q != 3'd0);
    head_id    = id_q[head_q];
  end

  // Request fields follow the inst side whenever data is not granted.
  always_comb begin
    mem_wr    = grant_data ? data_wr    : inst_wr;
    mem_size  = grant_data ? data_size  : inst_size;
    mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    mem_addr  = grant_data ? data_addr  : inst_addr;
    mem_wdata = grant_data ? data_wdata : inst_wdata;
  end

  // Response routing reads the registered head, so a same-cycle accept is never the target.
  always_comb begin
    inst_addr_ok = grant_inst & mem_addr_ok;
    data_addr_ok = grant_data & mem_addr_ok;
    inst_data_ok = pop & ~head_id;
    data_data_ok = pop &  head_id;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    ot_count     = count_q;
  end

  always_comb begin
    id_d    = id_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      id_d[tail_q] = grant_data;
      tail_d       = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      id_q    <= id_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: combinational grant/mux table, then ordered-response sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  ot_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.OT_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ot_count(ot_count)
  );

  typedef struct {
    logic        ir, dr, aok, dok;
    logic        e_req, e_iaok, e_daok, e_idok, e_ddok, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
  endtask

  logic exp_q[$];
  logic exp_side;

  initial begin
    reset = 1'b1;
    clr();
    mem_rdata = 32'h0;
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h3;
    inst_addr = 32'h1000_0000; inst_wdata = 32'hAAAA_AAAA;
    data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'hC;
    data_addr = 32'h2000_0000; data_wdata = 32'h5555_5555;

    //           ir   dr   aok  dok  req  iaok daok idok ddok wr   size  wstrb addr            wdata
    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,4'h3,32'h1000_0000,32'hAAAA_AAAA};
    vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,4'h3,32'h1000_0000,32'hAAAA_AAAA};
    vecs[2] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'd2,4'h3,32'h1000_0000,32'hAAAA_AAAA};
    vecs[3] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,2'd1,4'hC,32'h2000_0000,32'h5555_5555};
    vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,2'd1,4'hC,32'h2000_0000,32'h5555_5555};
    vecs[5] = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,4'hC,32'h2000_0000,32'h5555_5555};
    vecs[6] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,4'h3,32'h1000_0000,32'hAAAA_AAAA};
    vecs[7] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,4'hC,32'h2000_0000,32'h5555_5555};

    tick();
    tick();
    #1;
    check("reset ot_count", ot_count, 0);
    check("reset mem_req", mem_req, 0);

    // Reset held: state stays empty while combinational paths are exercised.
    foreach (vecs[i]) begin
      inst_req = vecs[i].ir; data_req = vecs[i].dr;
      mem_addr_ok = vecs[i].aok; mem_data_ok = vecs[i].dok;
      #1;
      check($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_req);
      check($sformatf("v%0d inst_addr_ok", i), inst_addr_ok, vecs[i].e_iaok);
      check($sformatf("v%0d data_addr_ok", i), data_addr_ok, vecs[i].e_daok);
      check($sformatf("v%0d inst_data_ok", i), inst_data_ok, vecs[i].e_idok);
      check($sformatf("v%0d data_data_ok", i), data_data_ok, vecs[i].e_ddok);
      check($sformatf("v%0d mem_wr", i), mem_wr, vecs[i].e_wr);
      check($sformatf("v%0d mem_size", i), mem_size, vecs[i].e_size);
      check($sformatf("v%0d mem_wstrb", i), mem_wstrb, vecs[i].e_wstrb);
      check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      clr();
      tick();
    end
    reset = 1'b0;
    tick();
    #1;
    check("post-reset ot_count", ot_count, 0);

    // Single fetch transaction.
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    #1;
    check("if mem_addr", mem_addr, 32'h1c00_0000);
    check("if inst_addr_ok", inst_addr_ok, 1);
    tick();
    clr(); mem_data_ok = 1'b1; mem_rdata = 32'h02c0_0000;
    #1;
    check("if ot_count", ot_count, 1);
    check("if inst_data_ok", inst_data_ok, 1);
    check("if data_data_ok", data_data_ok, 0);
    check("if inst_rdata", inst_rdata, 32'h02c0_0000);
    tick();
    clr();
    #1;
    check("if drained", ot_count, 0);

    // Contention: data first, inst next; responses in the same order.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    inst_addr = 32'h0000_0200; data_addr = 32'h0000_0100;
    #1;
    check("ct data grant", data_addr_ok, 1);
    check("ct inst held", inst_addr_ok, 0);
    check("ct mem_addr data", mem_addr, 32'h0000_0100);
    tick();
    data_req = 1'b0;
    #1;
    check("ct inst grant", inst_addr_ok, 1);
    check("ct mem_addr inst", mem_addr, 32'h0000_0200);
    tick();
    clr(); mem_data_ok = 1'b1;
    #1;
    check("ct count", ot_count, 2);
    check("ct rsp0 data", data_data_ok, 1);
    check("ct rsp0 not inst", inst_data_ok, 0);
    tick();
    #1;
    check("ct rsp1 inst", inst_data_ok, 1);
    check("ct rsp1 not data", data_data_ok, 0);
    tick();
    clr();
    #1;
    check("ct drained", ot_count, 0);

    // Full: two accepts block the third until a response frees a slot.
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    tick();
    #1;
    check("full count", ot_count, 2);
    check("full mem_req", mem_req, 0);
    check("full no addr_ok", inst_addr_ok, 0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    check("full pop inst_data_ok", inst_data_ok, 1);
    tick();
    mem_data_ok = 1'b0;
    #1;
    check("full freed mem_req", mem_req, 1);
    check("full freed count", ot_count, 1);
    inst_req = 1'b0; mem_data_ok = 1'b1;
    tick();
    clr();
    #1;
    check("full drained", ot_count, 0);

    // Simultaneous accept and response with one inst outstanding.
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    clr(); data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    check("sim data_addr_ok", data_addr_ok, 1);
    check("sim inst_data_ok", inst_data_ok, 1);
    check("sim data_data_ok", data_data_ok, 0);
    tick();
    clr(); mem_data_ok = 1'b1;
    #1;
    check("sim count", ot_count, 1);
    check("sim next to data", data_data_ok, 1);
    check("sim next not inst", inst_data_ok, 0);
    tick();
    clr();

    // Reset with two outstanding, then a stray response.
    data_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    tick();
    clr();
    #1;
    check("rst pre count", ot_count, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_data_ok = 1'b1;
    #1;
    check("rst count", ot_count, 0);
    check("rst stray inst", inst_data_ok, 0);
    check("rst stray data", data_data_ok, 0);
    tick();
    clr();
    #1;
    check("rst stray count", ot_count, 0);

    // Six alternating transactions pipelined so both pointers wrap several times.
    for (int k = 0; k < 7; k++) begin
      clr();
      if (k < 6) begin
        inst_req = (k % 2 == 0); data_req = (k % 2 == 1); mem_addr_ok = 1'b1;
      end
      if (k >= 1) begin
        mem_data_ok = 1'b1; mem_rdata = 32'hD000_0000 + 32'(k);
      end
      #1;
      if (k < 6) begin
        check($sformatf("wrap%0d addr_ok", k), (k % 2 == 0) ? inst_addr_ok : data_addr_ok, 1);
      end
      if (k >= 1) begin
        exp_side = exp_q.pop_front();
        check($sformatf("wrap%0d inst_data_ok", k), inst_data_ok, !exp_side);
        check($sformatf("wrap%0d data_data_ok", k), data_data_ok, exp_side);
        check($sformatf("wrap%0d rdata", k), exp_side ? data_rdata : inst_rdata, 32'hD000_0000 + 32'(k));
      end
      if (k < 6) exp_q.push_back(k % 2 == 1);
      tick();
    end
    clr();
    #1;
    check("wrap end count", ot_count, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
